// File: rtl/tc_timer_gen.sv
// tc_timer_gen: CNT_W-bit timer/counter with NCH compare channels on the 8-bit bus.
// Modes are normal, CTC and fast PWM, with a prescaled tick, W1C flags and a masked IRQ.
// Ports:
//   clk, rst (async active-low)
//   bus: write, read, addr, wdata, rdata (registered)
//   interrupt_request, oc_out[NCH]
//   ext_tick (only when TC_EXT_CLK_EN is defined)
// Option: define TC_EXT_CLK_EN to enable the synchronised external count source (CS=6/7).
module tc_timer_gen #(
  parameter int          CNT_W = 8,
  parameter int          NCH   = 2,
  parameter logic [7:0]  BASE  = 8'h24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           write,
  input  logic           read,
  input  logic [7:0]     addr,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata,
  output logic           interrupt_request,
  output logic [NCH-1:0] oc_out
`ifdef TC_EXT_CLK_EN
  ,
  input  logic           ext_tick
`endif
);

  localparam bit W16 = (CNT_W == 16);

  logic [2*NCH-1:0] r_com;
  logic [2:0]       r_cs;
  logic [1:0]       r_wgm;
  logic [CNT_W-1:0] r_tcnt;
  logic [NCH:0]     r_timsk;
  logic [NCH:0]     r_tifr;
  logic [CNT_W-1:0] r_ocr_buf [NCH];
  logic [CNT_W-1:0] r_ocr_eff [NCH];
  logic [7:0]       r_temp;
  logic [7:0]       r_rdata;
  logic [9:0]       r_pre;
  logic             r_supp;
  logic [NCH-1:0]   r_oc;

  logic [7:0]       w_off;
  logic             w_rd;
  logic             w_wr_tcnt;
  logic             w_wr_tccrb;
  logic [CNT_W-1:0] w_wval;
  logic [15:0]      w_tcnt16;
  logic [15:0]      w_ocr16 [NCH];
  logic [7:0]       w_rval;
  logic             w_tld;
  logic [7:0]       w_tval;
  logic             w_tick;
  logic             w_step;
  logic             w_pwm;
  logic [CNT_W-1:0] w_top;
  logic             w_at_top;
  logic [NCH:0]     w_set;
  logic [NCH:0]     w_clr;
  logic [NCH-1:0]   w_match;
  logic [NCH-1:0]   w_oc_nxt;
  logic [CNT_W-1:0] w_buf_nxt [NCH];
  logic [CNT_W-1:0] w_eff_nxt [NCH];

  assign w_off      = addr - BASE;
  assign w_rd       = read & ~write;
  assign w_wr_tcnt  = write && (w_off == 8'd2);
  assign w_wr_tccrb = write && (w_off == 8'd1);
  // Low-byte writes commit the TEMP high byte alongside wdata.
  assign w_wval     = CNT_W'({W16 ? r_temp : 8'h00, wdata});
  assign w_tcnt16   = 16'(r_tcnt);

  assign rdata             = r_rdata;
  assign oc_out            = r_oc;
  assign interrupt_request = |(r_tifr & r_timsk);

`ifdef TC_EXT_CLK_EN
  logic r_es1;
  logic r_es2;
  logic r_es3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_es1 <= 1'b0;
      r_es2 <= 1'b0;
      r_es3 <= 1'b0;
    end else begin
      r_es1 <= ext_tick;
      r_es2 <= r_es1;
      r_es3 <= r_es2;
    end
  end
`endif

  always_comb begin
    w_tick = 1'b0;
    unique case (r_cs)
      3'd1:    w_tick = 1'b1;
      3'd2:    w_tick = &r_pre[2:0];
      3'd3:    w_tick = &r_pre[5:0];
      3'd4:    w_tick = &r_pre[7:0];
      3'd5:    w_tick = &r_pre;
`ifdef TC_EXT_CLK_EN
      3'd6:    w_tick = r_es2 & ~r_es3;
      3'd7:    w_tick = ~r_es2 & r_es3;
`endif
      default: w_tick = 1'b0;
    endcase
  end

  assign w_step   = w_tick & ~w_wr_tcnt;
  assign w_pwm    = r_wgm[1];
  assign w_top    = r_wgm[0] ? r_ocr_eff[0] : '1;
  assign w_at_top = (r_tcnt == w_top);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_ocr16[i] = 16'(r_ocr_buf[i]);
    end
  end

  always_comb begin
    w_rval = 8'h00;
    w_tld  = 1'b0;
    w_tval = 8'h00;
    case (w_off)
      8'd0: w_rval = 8'(r_com);
      8'd1: w_rval = {3'b000, r_wgm, r_cs};
      8'd2: begin
        w_rval = w_tcnt16[7:0];
        w_tld  = W16;
        w_tval = w_tcnt16[15:8];
      end
      8'd3: w_rval = W16 ? r_temp : 8'h00;
      8'd4: w_rval = 8'(r_timsk);
      8'd5: w_rval = 8'(r_tifr);
      default: ;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (w_off == 8'(6 + 2*i)) begin
        w_rval = w_ocr16[i][7:0];
        w_tld  = W16;
        w_tval = w_ocr16[i][15:8];
      end
      if (w_off == 8'(7 + 2*i)) begin
        w_rval = W16 ? r_temp : 8'h00;
      end
    end
  end

  always_comb begin
    w_set    = '0;
    w_set[0] = w_step & w_at_top;
    w_clr    = (write && w_off == 8'd5) ? wdata[NCH:0] : '0;
    w_match  = '0;
    w_oc_nxt = r_oc;
    for (int i = 0; i < NCH; i++) begin
      w_buf_nxt[i] = r_ocr_buf[i];
      w_eff_nxt[i] = r_ocr_eff[i];
      if (w_step && w_at_top && w_pwm) begin
        w_eff_nxt[i] = r_ocr_buf[i];
      end
      // Leaving PWM releases the buffered value immediately.
      if (w_wr_tccrb && !wdata[4]) begin
        w_eff_nxt[i] = r_ocr_buf[i];
      end
      if (write && w_off == 8'(6 + 2*i)) begin
        w_buf_nxt[i] = w_wval;
        if (!w_pwm) begin
          w_eff_nxt[i] = w_wval;
        end
      end
      w_match[i]  = w_step && !r_supp && (r_tcnt == r_ocr_eff[i]);
      w_set[i+1]  = w_match[i];
      if (w_pwm) begin
        // Wrap beats match; a zero compare value keeps the pin at its off level.
        if (r_com[2*i+1]) begin
          if (w_step && w_at_top) begin
            w_oc_nxt[i] = (r_ocr_buf[i] != '0) ^ r_com[2*i];
          end else if (w_match[i]) begin
            w_oc_nxt[i] = r_com[2*i];
          end
        end
      end else if (w_match[i]) begin
        unique case (r_com[2*i +: 2])
          2'b01:   w_oc_nxt[i] = ~r_oc[i];
          2'b10:   w_oc_nxt[i] = 1'b0;
          2'b11:   w_oc_nxt[i] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_com   <= '0;
      r_cs    <= '0;
      r_wgm   <= '0;
      r_tcnt  <= '0;
      r_timsk <= '0;
      r_tifr  <= '0;
      r_temp  <= '0;
      r_rdata <= '0;
      r_pre   <= '0;
      r_supp  <= 1'b0;
      r_oc    <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_ocr_buf[i] <= '0;
        r_ocr_eff[i] <= '0;
      end
    end else begin
      if (write) begin
        case (w_off)
          8'd0: r_com <= wdata[2*NCH-1:0];
          8'd1: begin
            r_cs  <= wdata[2:0];
            r_wgm <= wdata[4:3];
          end
          8'd3: if (W16) r_temp <= wdata;
          8'd4: r_timsk <= wdata[NCH:0];
          default: ;
        endcase
        for (int i = 0; i < NCH; i++) begin
          if (W16 && w_off == 8'(7 + 2*i)) begin
            r_temp <= wdata;
          end
        end
      end else if (w_rd && w_tld) begin
        r_temp <= w_tval;
      end
      if (w_rd) begin
        r_rdata <= w_rval;
      end
      if (w_wr_tccrb && wdata[2:0] != r_cs) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_wr_tcnt) begin
        r_tcnt <= w_wval;
      end else if (w_step) begin
        r_tcnt <= w_at_top ? '0 : r_tcnt + 1'b1;
      end
      if (w_wr_tcnt) begin
        r_supp <= 1'b1;
      end else if (w_tick) begin
        r_supp <= 1'b0;
      end
      r_tifr <= (r_tifr & ~w_clr) | w_set;
      r_oc   <= w_oc_nxt;
      for (int i = 0; i < NCH; i++) begin
        r_ocr_buf[i] <= w_buf_nxt[i];
        r_ocr_eff[i] <= w_eff_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_tc_timer_gen.sv
// tb_tc_timer_gen: directed checks of tc_timer_gen.
// u8 is the 8-bit build, u16 the 16-bit build; both use BASE 8'h24.
module tb_tc_timer_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wr8, rd8, wr16, rd16;
  logic [7:0] rdata8, rdata16;
  logic       irq8, irq16;
  logic [1:0] oc8, oc16;
`ifdef TC_EXT_CLK_EN
  logic       ext8;
  logic       ext16;
`endif
  logic [7:0] d;
  int         vec = 0;
  int         bad = 0;
  int         cyc = 0;
  int         t0  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tc_timer_gen #(.CNT_W(8), .NCH(2), .BASE(8'h24)) u8 (
    .clk(clk), .rst(rst), .write(wr8), .read(rd8),
    .addr(addr), .wdata(wdata), .rdata(rdata8),
    .interrupt_request(irq8), .oc_out(oc8)
`ifdef TC_EXT_CLK_EN
    , .ext_tick(ext8)
`endif
  );

  tc_timer_gen #(.CNT_W(16), .NCH(2), .BASE(8'h24)) u16 (
    .clk(clk), .rst(rst), .write(wr16), .read(rd16),
    .addr(addr), .wdata(wdata), .rdata(rdata16),
    .interrupt_request(irq16), .oc_out(oc16)
`ifdef TC_EXT_CLK_EN
    , .ext_tick(ext16)
`endif
  );

  task automatic bw(input bit big, input logic [7:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    addr = a;
    wdata = v;
    if (big) wr16 = 1'b1;
    else wr8 = 1'b1;
    @(posedge clk); #1;
    wr8 = 1'b0;
    wr16 = 1'b0;
  endtask

  task automatic br(input bit big, input logic [7:0] a, output logic [7:0] v);
    @(posedge clk); #1;
    addr = a;
    if (big) rd16 = 1'b1;
    else rd8 = 1'b1;
    @(posedge clk); #1;
    rd8 = 1'b0;
    rd16 = 1'b0;
    v = big ? rdata16 : rdata8;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc - t0 < k) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    addr = 8'h00;
    wdata = 8'h00;
    wr8 = 1'b0; rd8 = 1'b0; wr16 = 1'b0; rd16 = 1'b0;
`ifdef TC_EXT_CLK_EN
    ext8 = 1'b0;
    ext16 = 1'b0;
`endif
    #12;
    chk("rst_rdata8", rdata8, 8'h00);
    chk("rst_oc8", oc8, 2'b00);
    chk("rst_irq8", irq8, 1'b0);
    chk("rst_rdata16", rdata16, 8'h00);
    @(posedge clk); #2;
    rst = 1'b1;

    // overflow and interrupt, 8-bit
    bw(0, 8'h28, 8'h01);
    bw(0, 8'h25, 8'h01);
    t0 = cyc;
    wait_to(255);
    chk("t2_no_tov_255", irq8, 1'b0);
    wait_to(256);
    chk("t2_tov_256", irq8, 1'b1);
    br(0, 8'h29, d);
    chk("t2_tifr", d, 8'h07);
    bw(0, 8'h29, 8'h01);
    chk("t2_w1c_irq", irq8, 1'b0);
    br(0, 8'h29, d);
    chk("t2_tifr_after_clr", d, 8'h06);
    bw(0, 8'h25, 8'h00);
    bw(0, 8'h26, 8'h80);
    br(0, 8'h26, d);
    chk("t2_tcnt_wr", d, 8'h80);
    bw(0, 8'h27, 8'h55);
    br(0, 8'h27, d);
    chk("t2_h_reads0", d, 8'h00);
    br(0, 8'h25, d);
    chk("t2_tccrb_rd", d, 8'h00);

    // CTC toggle
    bw(0, 8'h26, 8'h00);
    bw(0, 8'h2A, 8'd9);
    bw(0, 8'h24, 8'h01);
    bw(0, 8'h29, 8'hFF);
    bw(0, 8'h25, 8'h09);
    t0 = cyc;
    wait_to(9);
    chk("t3_oc_before", oc8[0], 1'b0);
    wait_to(10);
    chk("t3_oc_tog1", oc8[0], 1'b1);
    wait_to(19);
    chk("t3_oc_hold", oc8[0], 1'b1);
    wait_to(20);
    chk("t3_oc_tog2", oc8[0], 1'b0);
    br(0, 8'h29, d);
    chk("t3_ocf0", d[1], 1'b1);
    bw(0, 8'h25, 8'h00);
    bw(0, 8'h24, 8'h00);

    // fast PWM, TOP=MAX
    bw(0, 8'h2C, 8'd64);
    bw(0, 8'h24, 8'h08);
    bw(0, 8'h26, 8'hFF);
    bw(0, 8'h25, 8'h11);
    t0 = cyc;
    wait_to(1);
    chk("t4_wrap_high", oc8[1], 1'b1);
    wait_to(65);
    chk("t4_high_end", oc8[1], 1'b1);
    wait_to(66);
    chk("t4_low_start", oc8[1], 1'b0);
    wait_to(256);
    chk("t4_low_end", oc8[1], 1'b0);
    wait_to(257);
    chk("t4_wrap2", oc8[1], 1'b1);
    wait_to(268);
    bw(0, 8'h2C, 8'd128);
    wait_to(321);
    chk("t4_old_duty_hi", oc8[1], 1'b1);
    wait_to(322);
    chk("t4_old_duty_lo", oc8[1], 1'b0);
    wait_to(513);
    chk("t4_wrap3", oc8[1], 1'b1);
    wait_to(641);
    chk("t4_new_duty_hi", oc8[1], 1'b1);
    wait_to(642);
    chk("t4_new_duty_lo", oc8[1], 1'b0);
    bw(0, 8'h25, 8'h00);

    // 16-bit TEMP access
    bw(1, 8'h27, 8'h12);
    bw(1, 8'h26, 8'h34);
    br(1, 8'h26, d);
    chk("t5_tcnt_l", d, 8'h34);
    br(1, 8'h27, d);
    chk("t5_tcnt_h", d, 8'h12);
    bw(1, 8'h2B, 8'hAB);
    bw(1, 8'h2A, 8'hCD);
    br(1, 8'h2A, d);
    chk("t5_ocr_l", d, 8'hCD);
    br(1, 8'h2B, d);
    chk("t5_ocr_h", d, 8'hAB);
    bw(1, 8'h2B, 8'h00);
    bw(1, 8'h2A, 8'h00);
    bw(1, 8'h27, 8'h12);
    bw(1, 8'h26, 8'hFE);
    bw(1, 8'h25, 8'h01);
    br(1, 8'h26, d);
    chk("t5_snap_l", d, 8'hFF);
    br(1, 8'h27, d);
    chk("t5_snap_h", d, 8'h12);
    bw(1, 8'h25, 8'h00);
    br(1, 8'h26, d);
    chk("t5_stop_l", d, 8'h04);
    br(1, 8'h27, d);
    chk("t5_stop_h", d, 8'h13);

    // prescaler /8
    bw(1, 8'h27, 8'hFF);
    bw(1, 8'h26, 8'hFF);
    bw(1, 8'h29, 8'hFF);
    bw(1, 8'h28, 8'h01);
    bw(1, 8'h25, 8'h02);
    t0 = cyc;
    wait_to(7);
    chk("t6_no_tick_7", irq16, 1'b0);
    wait_to(8);
    chk("t6_tick_8", irq16, 1'b1);
    bw(1, 8'h29, 8'h01);
    wait_to(39);
    bw(1, 8'h25, 8'h00);
    br(1, 8'h26, d);
    chk("t6_cnt_l", d, 8'h04);
    br(1, 8'h27, d);
    chk("t6_cnt_h", d, 8'h00);

    // external source
    bw(1, 8'h27, 8'h00);
    bw(1, 8'h26, 8'h00);
    bw(1, 8'h25, 8'h06);
`ifdef TC_EXT_CLK_EN
    repeat (5) begin
      ext16 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      ext16 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
`else
    repeat (40) @(posedge clk);
    #1;
`endif
    br(1, 8'h25, d);
    chk("t6_cs6_rd", d, 8'h06);
    bw(1, 8'h25, 8'h00);
    br(1, 8'h26, d);
`ifdef TC_EXT_CLK_EN
    chk("t6_ext_cnt", d, 8'h05);
`else
    chk("t6_ext_stopped", d, 8'h00);
`endif

    // reset mid-count
    bw(0, 8'h2C, 8'd100);
    bw(0, 8'h24, 8'h08);
    bw(0, 8'h28, 8'h07);
    bw(0, 8'h25, 8'h11);
    repeat (30) @(posedge clk);
    br(0, 8'h25, d);
    chk("t1_pre_rdata", d, 8'h11);
    #3;
    rst = 1'b0;
    #1;
    chk("t1_rdata", rdata8, 8'h00);
    chk("t1_oc", oc8, 2'b00);
    chk("t1_irq", irq8, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      br(0, 8'(8'h24 + i), d);
      chk($sformatf("t1_reg%0d", i), d, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
